// File: rtl/smachine_pkg.sv
// Shared definitions for the S-Machine control unit: opcodes, FSM states,
// write-back select codes, branch conditions and small decode helpers.
package smachine_pkg;

   localparam logic [3:0] OP_LDI  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_INC  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_ST   = 4'h7;
   localparam logic [3:0] OP_LD   = 4'h8;
   localparam logic [3:0] OP_SHR  = 4'h9;
   localparam logic [3:0] OP_EXCH = 4'hA;
   localparam logic [3:0] OP_CMP  = 4'hB;
   localparam logic [3:0] OP_MOV  = 4'hC;
   localparam logic [3:0] OP_SET  = 4'hD;
   localparam logic [3:0] OP_CLR  = 4'hE;
   localparam logic [3:0] OP_BR   = 4'hF;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      FETCH  = 4'd1,
      DECODE = 4'd2,
      FOP    = 4'd3,
      EXEC   = 4'd4,
      MRD    = 4'd5,
      MWR    = 4'd6,
      EXCH2  = 4'd7,
      FAULT  = 4'd8
   } state_t;

   localparam logic [1:0] WB_ALU   = 2'b00;
   localparam logic [1:0] WB_MEM   = 2'b01;
   localparam logic [1:0] WB_OPND  = 2'b10;
   localparam logic [1:0] WB_OTHER = 2'b11;

   localparam logic [1:0] BR_ALWAYS = 2'b00;
   localparam logic [1:0] BR_Z      = 2'b01;
   localparam logic [1:0] BR_N      = 2'b10;
   localparam logic [1:0] BR_C      = 2'b11;

   // Instructions that carry an immediate/address byte after the opcode.
   function automatic logic is_two_byte(input logic [3:0] op);
      return (op == OP_LDI) || (op == OP_ST) || (op == OP_LD) || (op == OP_BR);
   endfunction

   // flags is {C,N,Z}.
   function automatic logic br_taken(input logic [1:0] cond, input logic [2:0] flags);
      logic taken;
      case (cond)
         BR_ALWAYS: taken = 1'b1;
         BR_Z:      taken = flags[0];
         BR_N:      taken = flags[1];
         default:   taken = flags[2];
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/smachine_control_unit_if.sv
// Memory port of the S-Machine control unit.
// Handshake: mem_req rises with mem_we/mem_addr_sel valid and stays high
// until a cycle in which mem_ack is high; that cycle completes the transfer
// and mem_rdata is valid in it. mem_ack while mem_req is low is ignored.
interface smachine_control_unit_if #(parameter int DATA_W = 8);
   logic              mem_req;
   logic              mem_we;
   logic              mem_addr_sel;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (output mem_req, mem_we, mem_addr_sel, input mem_ack, mem_rdata);
   modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ack, mem_rdata);
endinterface

// File: rtl/smachine_mem_port.sv
// Request/acknowledge tracker with a wait-cycle timeout. A request starts the
// cycle after start_i and is held until ack or timeout; both end it.
module smachine_mem_port #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic mem_ack_i,
   output logic req_o,
   output logic ack_o,
   output logic timeout_o
);
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   logic             req_q, req_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign req_o     = req_q;
   assign ack_o     = req_q & mem_ack_i;
   assign timeout_o = req_q & ~mem_ack_i & (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

   // Next request/wait-count state: open on start, close on ack or timeout.
   always_comb begin
      req_d = req_q;
      cnt_d = cnt_q;
      if (req_q) begin
         if (mem_ack_i || timeout_o) begin
            req_d = 1'b0;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (start_i) begin
         req_d = 1'b1;
         cnt_d = '0;
      end
   end

   // Request and wait-count registers; reset drops an open request at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         req_q <= req_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/smachine_control_unit.sv
// S-Machine multi-cycle instruction sequencer: fetch, decode, operand fetch,
// execute and memory phases driving datapath strobes.
// Optional SMC_SINGLE_STEP_EN: adds a `step` input; after each instruction the
// FSM parks in IDLE until a rising edge of step while enable is high.
module smachine_control_unit
   import smachine_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
`ifdef SMC_SINGLE_STEP_EN
   input  logic                        step,
`endif
   smachine_control_unit_if.master     mem,
   output logic                        pc_inc,
   output logic                        pc_load,
   output logic [DATA_W-1:0]           operand,
   output logic [3:0]                  alu_op,
   output logic                        reg_dst,
   output logic                        reg_we,
   output logic [1:0]                  wb_sel,
   output logic                        flags_we,
   input  logic [2:0]                  flags,
   output logic                        instr_done,
   output logic                        fault,
   output logic [3:0]                  state_o
);
`ifdef SMC_SINGLE_STEP_EN
   localparam state_t AFTER_DONE = IDLE;
`else
   localparam state_t AFTER_DONE = FETCH;
`endif

   state_t            state_q, state_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] operand_q, operand_d;
   logic              mem_start, mem_we_c, addr_sel_c;
   logic              req, ack, timeout;
   logic [3:0]        opcode;
   // The src bit picks the "other" register inside the datapath only.
   logic              src_unused;

   assign opcode     = ir_q[7:4];
   assign src_unused = ir_q[1];

   smachine_mem_port #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_port (
      .clk       (clk),
      .reset     (reset),
      .start_i   (mem_start),
      .mem_ack_i (mem.mem_ack),
      .req_o     (req),
      .ack_o     (ack),
      .timeout_o (timeout)
   );

   assign mem.mem_req      = req;
   assign mem.mem_we       = mem_we_c;
   assign mem.mem_addr_sel = addr_sel_c;
   assign operand          = operand_q;
   assign alu_op           = opcode;
   assign fault            = (state_q == FAULT);
   assign state_o          = state_q;

`ifdef SMC_SINGLE_STEP_EN
   logic step_q, step_d;
   // Previous step level for rising-edge detection.
   always_comb step_d = step;
   // Step history register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) step_q <= 1'b0;
      else       step_q <= step_d;
   end
`endif

   // Next-state, register loads and per-cycle strobes.
   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      operand_d  = operand_q;
      mem_start  = 1'b0;
      mem_we_c   = 1'b0;
      addr_sel_c = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = ir_q[0];
      wb_sel     = WB_ALU;
      flags_we   = 1'b0;
      instr_done = 1'b0;
      case (state_q)
         IDLE: begin
`ifdef SMC_SINGLE_STEP_EN
            if (enable && step && !step_q) state_d = FETCH;
`else
            if (enable) state_d = FETCH;
`endif
         end
         // No open request means this is the entry cycle: enable decides.
         FETCH: begin
            if (!req) begin
               if (enable) mem_start = 1'b1;
               else        state_d   = IDLE;
            end else if (ack) begin
               ir_d    = mem.mem_rdata;
               pc_inc  = 1'b1;
               state_d = DECODE;
            end else if (timeout) begin
               state_d = FAULT;
            end
         end
         DECODE: state_d = is_two_byte(opcode) ? FOP : EXEC;
         FOP: begin
            if (!req) begin
               mem_start = 1'b1;
            end else if (ack) begin
               operand_d = mem.mem_rdata;
               pc_inc    = 1'b1;
               state_d   = EXEC;
            end else if (timeout) begin
               state_d = FAULT;
            end
         end
         EXEC: begin
            instr_done = 1'b1;
            state_d    = AFTER_DONE;
            case (opcode)
               OP_ADD, OP_SUB, OP_INC, OP_OR, OP_AND, OP_XOR, OP_SHR: begin
                  reg_we   = 1'b1;
                  flags_we = 1'b1;
               end
               OP_CMP: flags_we = 1'b1;
               OP_LDI: begin
                  reg_we = 1'b1;
                  wb_sel = WB_OPND;
               end
               OP_MOV: begin
                  reg_we = 1'b1;
                  wb_sel = WB_OTHER;
               end
               // ALU produces 0xFF/0x00 for these opcodes; flags untouched.
               OP_SET, OP_CLR: reg_we = 1'b1;
               OP_BR: pc_load = br_taken(ir_q[3:2], flags);
               // Address is already in the operand register, so the data
               // request is opened here to save a cycle.
               OP_LD: begin
                  instr_done = 1'b0;
                  mem_start  = 1'b1;
                  state_d    = MRD;
               end
               OP_ST: begin
                  instr_done = 1'b0;
                  mem_start  = 1'b1;
                  state_d    = MWR;
               end
               // First half of exchange: dst <= other, datapath saves old dst.
               OP_EXCH: begin
                  instr_done = 1'b0;
                  reg_we     = 1'b1;
                  wb_sel     = WB_OTHER;
                  state_d    = EXCH2;
               end
               default: ;
            endcase
         end
         MRD: begin
            addr_sel_c = 1'b1;
            if (ack) begin
               reg_we     = 1'b1;
               wb_sel     = WB_MEM;
               instr_done = 1'b1;
               state_d    = AFTER_DONE;
            end else if (timeout) begin
               state_d = FAULT;
            end
         end
         MWR: begin
            addr_sel_c = 1'b1;
            mem_we_c   = 1'b1;
            if (ack) begin
               instr_done = 1'b1;
               state_d    = AFTER_DONE;
            end else if (timeout) begin
               state_d = FAULT;
            end
         end
         // Second half of exchange: other <= saved temp (datapath routes it).
         EXCH2: begin
            reg_we     = 1'b1;
            reg_dst    = ~ir_q[0];
            wb_sel     = WB_OTHER;
            instr_done = 1'b1;
            state_d    = AFTER_DONE;
         end
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
   end

   // State, instruction and operand registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         ir_q      <= '0;
         operand_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         operand_q <= operand_d;
      end
   end
endmodule

// File: tb/tb_smachine_control_unit.sv
// Bench for smachine_control_unit: scripted memory responder plus scoreboard
// of expected register writes and per-instruction completion records.
module tb_smachine_control_unit;
   import smachine_pkg::*;

   logic       clk = 1'b0;
   logic       reset, enable;
   logic       pc_inc, pc_load, reg_dst, reg_we, flags_we, instr_done, fault;
   logic [7:0] operand;
   logic [3:0] alu_op, state_o;
   logic [1:0] wb_sel;
   logic [2:0] flags;

   smachine_control_unit_if #(.DATA_W(8)) mem_if ();

   smachine_control_unit #(.DATA_W(8), .MEM_TIMEOUT(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .mem        (mem_if),
      .pc_inc     (pc_inc),
      .pc_load    (pc_load),
      .operand    (operand),
      .alu_op     (alu_op),
      .reg_dst    (reg_dst),
      .reg_we     (reg_we),
      .wb_sel     (wb_sel),
      .flags_we   (flags_we),
      .flags      (flags),
      .instr_done (instr_done),
      .fault      (fault),
      .state_o    (state_o)
   );

   // Clock
   always #5 clk = ~clk;

   // Completion record: {latency[7:0], pc_incs[1:0], pc_load, flags_we, mem_we, operand[7:0], alu_op[3:0]}
   logic [24:0] exp_q[$];
   // Register write: {reg_dst, wb_sel}
   logic [2:0]  wr_q[$];
   // Memory script: {delay[3:0], we, addr_sel, data[7:0]}
   logic [13:0] mreq_q[$];

   int         tests_run = 0;
   int         tests_failed = 0;
   int         wait_cnt = 0;
   int         cyc = 0;
   int         start_cyc = 0;
   int         pcinc_cnt = 0;
   logic [3:0] prev_state = 4'd0;
   logic [7:0] exp_opnd = 8'h00;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Queue one instruction: memory script, expected writes and completion.
   task automatic issue(input logic [7:0] ir, input logic [7:0] opnd, input int d_f,
                        input int d_o, input int d_m, input logic [7:0] ldata);
      logic [3:0] op;
      logic       two, taken, fwe;
      int         lat;
      op  = ir[7:4];
      two = (op == 4'h0) || (op == 4'h7) || (op == 4'h8) || (op == 4'hF);
      mreq_q.push_back({d_f[3:0], 2'b00, ir});
      lat = 4 + d_f;
      if (two) begin
         mreq_q.push_back({d_o[3:0], 2'b00, opnd});
         exp_opnd = opnd;
         lat = 6 + d_f + d_o;
      end
      if (op == 4'h8) mreq_q.push_back({d_m[3:0], 2'b01, ldata});
      if (op == 4'h7) mreq_q.push_back({d_m[3:0], 2'b11, 8'h00});
      if (op == 4'h7 || op == 4'h8) lat = 7 + d_f + d_o + d_m;
      if (op == 4'hA) lat = 5 + d_f;
      case (ir[3:2])
         2'd0:    taken = 1'b1;
         2'd1:    taken = flags[0];
         2'd2:    taken = flags[1];
         default: taken = flags[2];
      endcase
      taken = taken && (op == 4'hF);
      fwe = (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9, 4'hB});
      exp_q.push_back({8'(lat), (two ? 2'd2 : 2'd1), taken, fwe, (op == 4'h7), exp_opnd, op});
      case (op)
         4'h0: wr_q.push_back({ir[0], 2'b10});
         4'h8: wr_q.push_back({ir[0], 2'b01});
         4'hC: wr_q.push_back({ir[0], 2'b11});
         4'hA: begin
            wr_q.push_back({ir[0], 2'b11});
            wr_q.push_back({~ir[0], 2'b11});
         end
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9, 4'hD, 4'hE: wr_q.push_back({ir[0], 2'b00});
         default: ;
      endcase
   endtask

   // One clock: memory responds after the edge, outputs are checked at negedge.
   task automatic cycle_step();
      logic [13:0] e;
      @(posedge clk);
      #1;
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = 8'($urandom_range(0, 255));
      if (mem_if.mem_req) begin
         if (mreq_q.size() > 0) begin
            e = mreq_q[0];
            if (wait_cnt >= int'(e[13:10])) begin
               mem_if.mem_ack   = 1'b1;
               mem_if.mem_rdata = e[7:0];
               check_eq("mem_ctl", {mem_if.mem_we, mem_if.mem_addr_sel}, e[9:8]);
               void'(mreq_q.pop_front());
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end
      end else begin
         wait_cnt = 0;
         // Stray acks outside a request must be ignored.
         mem_if.mem_ack = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      cyc++;
      if (state_o == FETCH && prev_state != FETCH) begin
         start_cyc = cyc;
         pcinc_cnt = 0;
      end
      if (pc_inc) pcinc_cnt++;
      if (reg_we) begin
         if (wr_q.size() == 0) check_eq("wr_unexpected", 1, 0);
         else check_eq("reg_write", {reg_dst, wb_sel}, wr_q.pop_front());
      end
      if (instr_done) begin
         if (exp_q.size() == 0) check_eq("done_unexpected", 1, 0);
         else check_eq("instr_done", {8'(cyc - start_cyc + 1), 2'(pcinc_cnt), pc_load, flags_we,
                                      mem_if.mem_we, operand, alu_op}, exp_q.pop_front());
      end
      prev_state = state_o;
   endtask

   task automatic run_batch(input bit drop_early);
      int budget;
      int n_req;
      budget = 500;
      enable = 1'b1;
      while (exp_q.size() > 0 && budget > 0) begin
         cycle_step();
         budget--;
         if (drop_early && state_o == DECODE) enable = 1'b0;
      end
      enable = 1'b0;
      check_eq("batch_drained", exp_q.size(), 0);
      check_eq("writes_drained", wr_q.size(), 0);
      check_eq("mem_script_drained", mreq_q.size(), 0);
      n_req = 0;
      repeat (4) begin
         cycle_step();
         if (mem_if.mem_req) n_req++;
      end
      check_eq("idle_after_batch", state_o, IDLE);
      check_eq("no_req_after_batch", n_req, 0);
   endtask

   initial begin
      logic [3:0] ops [11];
      logic [3:0] op;
      int         n_req, budget;
      ops = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE};
      reset = 1'b1;
      enable = 1'b0;
      flags = 3'b000;
      mem_if.mem_ack = 1'b0;
      mem_if.mem_rdata = 8'h00;
      #20;
      check_eq("reset_state", state_o, IDLE);
      check_eq("reset_req", mem_if.mem_req, 0);
      check_eq("reset_pc_inc", pc_inc, 0);
      check_eq("reset_fault", fault, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) cycle_step();
      check_eq("idle_hold", state_o, IDLE);
      check_eq("idle_no_req", mem_if.mem_req, 0);

      // LDI, slow ST, taken BR Z, EXCH, LD with fetch waits
      flags = 3'b001;
      issue(8'h00, 8'h02, 0, 0, 0, 8'h00);
      issue(8'h71, 8'h55, 0, 0, 3, 8'h00);
      issue(8'hF4, 8'h10, 0, 0, 0, 8'h00);
      issue(8'hA0, 8'h00, 0, 0, 0, 8'h00);
      issue(8'h81, 8'h33, 1, 2, 0, 8'h5A);
      run_batch(1'b0);

      // Branch conditions with clear flags
      flags = 3'b000;
      issue(8'hF4, 8'h20, 0, 0, 0, 8'h00);
      issue(8'hF0, 8'h21, 0, 1, 0, 8'h00);
      issue(8'hF8, 8'h22, 0, 0, 0, 8'h00);
      issue(8'hB1, 8'h00, 0, 0, 0, 8'h00);
      run_batch(1'b0);

      // Random one-byte ops and branches
      flags = 3'($urandom_range(0, 7));
      for (int i = 0; i < 10; i++) begin
         op = ops[$urandom_range(0, 10)];
         issue({op, 4'($urandom_range(0, 15))}, 8'h00, $urandom_range(0, 2), 0, 0, 8'h00);
      end
      issue({4'hF, 2'($urandom_range(0, 3)), 2'b00}, 8'($urandom_range(0, 255)), 0,
            $urandom_range(0, 2), 0, 8'h00);
      issue({4'hF, 2'($urandom_range(0, 3)), 2'b00}, 8'($urandom_range(0, 255)), 1, 0, 0, 8'h00);
      run_batch(1'b0);

      // enable falls mid-instruction: LD still completes, then IDLE
      issue(8'h80, 8'h20, 0, 1, 1, 8'hC3);
      run_batch(1'b1);

      // Memory never acknowledges: timeout into FAULT
      enable = 1'b1;
      n_req = 0;
      budget = 60;
      while (!fault && budget > 0) begin
         cycle_step();
         if (mem_if.mem_req) n_req++;
         budget--;
      end
      check_eq("timeout_fault", fault, 1);
      check_eq("timeout_req_cycles", n_req, 15);
      check_eq("fault_state", state_o, FAULT);
      check_eq("fault_req_low", mem_if.mem_req, 0);
      repeat (3) cycle_step();
      check_eq("fault_sticky", state_o, FAULT);
      check_eq("fault_no_pc_inc", pc_inc, 0);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check_eq("async_reset_state", state_o, IDLE);
      check_eq("async_reset_fault", fault, 0);
      check_eq("async_reset_req", mem_if.mem_req, 0);
      enable = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
